// File: rtl/accelerator_tensor_float_adder_scheduler.sv
// Tensor add/sub sequencer: walks (i,j) and runs one SIZE_K vector op per pair on a shared vector float adder.
// Optional watchdog on RESULT/VWAIT: define ACCELERATOR_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN (adds TIMEOUT_CYCLES, o_error).
//
// state   | meaning
// IDLE    | waiting for i_start; sizes and operation latched on start
// VSTART  | one-cycle o_vector_start for the current (i,j) pair
// FEED    | o_data_in_ready high, waiting for an A/B pair
// RESULT  | operands issued, waiting for the vector result
// VWAIT   | all K results returned, waiting for i_vector_ready
// ENDER   | o_ready pulse, then back to IDLE
module accelerator_tensor_float_adder_scheduler #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
`ifdef ACCELERATOR_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_ready,
    input  logic                 i_operation,
    input  logic [DATA_SIZE-1:0] i_size_i_in,
    input  logic [DATA_SIZE-1:0] i_size_j_in,
    input  logic [DATA_SIZE-1:0] i_size_k_in,
    input  logic                 i_data_in_enable,
    output logic                 o_data_in_ready,
    input  logic [DATA_SIZE-1:0] i_data_a_in,
    input  logic [DATA_SIZE-1:0] i_data_b_in,
    output logic [DATA_SIZE-1:0] o_data_out,
    output logic                 o_data_out_i_enable,
    output logic                 o_data_out_j_enable,
    output logic                 o_data_out_k_enable,
    output logic                 o_vector_start,
    input  logic                 i_vector_ready,
    output logic                 o_vector_operation,
    output logic [DATA_SIZE-1:0] o_vector_size,
    output logic                 o_vector_data_a_enable,
    output logic                 o_vector_data_b_enable,
    output logic [DATA_SIZE-1:0] o_vector_data_a,
    output logic [DATA_SIZE-1:0] o_vector_data_b,
    input  logic                 i_vector_data_out_enable,
    input  logic [DATA_SIZE-1:0] i_vector_data_out
`ifdef ACCELERATOR_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    ,
    output logic                 o_error
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSTART = 3'd1,
        ST_FEED   = 3'd2,
        ST_RESULT = 3'd3,
        ST_VWAIT  = 3'd4,
        ST_ENDER  = 3'd5
    } state_t;

    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

    state_t r_state;
    state_t w_next_state;

    logic [DATA_SIZE-1:0] r_size_i;
    logic [DATA_SIZE-1:0] r_size_j;
    logic [DATA_SIZE-1:0] r_size_k;
    logic                 r_operation;
    logic [DATA_SIZE-1:0] r_i;
    logic [DATA_SIZE-1:0] r_j;
    logic [DATA_SIZE-1:0] r_k;

    logic                 r_ready;
    logic                 r_vector_start;
    logic                 r_operand_enable;
    logic [DATA_SIZE-1:0] r_vector_data_a;
    logic [DATA_SIZE-1:0] r_vector_data_b;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_out_i_enable;
    logic                 r_out_j_enable;
    logic                 r_out_k_enable;

    logic w_zero_size;
    logic w_last_i;
    logic w_last_j;
    logic w_last_k;
    logic w_timeout;

    assign w_zero_size = (i_size_i_in == '0) || (i_size_j_in == '0) || (i_size_k_in == '0);
    assign w_last_i    = (r_i == r_size_i - ONE);
    assign w_last_j    = (r_j == r_size_j - ONE);
    assign w_last_k    = (r_k == r_size_k - ONE);

`ifdef ACCELERATOR_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_error;

    assign w_timeout = ((r_state == ST_RESULT) || (r_state == ST_VWAIT)) &&
                       (r_wdog == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = w_zero_size ? ST_ENDER : ST_VSTART;
                end
            end
            ST_VSTART: begin
                w_next_state = ST_FEED;
            end
            ST_FEED: begin
                if (i_data_in_enable) begin
                    w_next_state = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (i_vector_data_out_enable) begin
                    w_next_state = w_last_k ? ST_VWAIT : ST_FEED;
                end
            end
            ST_VWAIT: begin
                if (i_vector_ready) begin
                    w_next_state = (w_last_i && w_last_j) ? ST_ENDER : ST_VSTART;
                end
            end
            ST_ENDER: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // A stalled vector unit abandons the whole tensor operation.
        if (w_timeout) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_size_i         <= '0;
            r_size_j         <= '0;
            r_size_k         <= '0;
            r_operation      <= 1'b0;
            r_i              <= '0;
            r_j              <= '0;
            r_k              <= '0;
            r_ready          <= 1'b0;
            r_vector_start   <= 1'b0;
            r_operand_enable <= 1'b0;
            r_vector_data_a  <= '0;
            r_vector_data_b  <= '0;
            r_data_out       <= '0;
            r_out_i_enable   <= 1'b0;
            r_out_j_enable   <= 1'b0;
            r_out_k_enable   <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_ready          <= (w_next_state == ST_ENDER) || w_timeout;
            r_vector_start   <= (w_next_state == ST_VSTART);
            r_operand_enable <= 1'b0;
            r_out_i_enable   <= 1'b0;
            r_out_j_enable   <= 1'b0;
            r_out_k_enable   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_size_i    <= i_size_i_in;
                        r_size_j    <= i_size_j_in;
                        r_size_k    <= i_size_k_in;
                        r_operation <= i_operation;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_k         <= '0;
                    end
                end
                ST_FEED: begin
                    if (i_data_in_enable) begin
                        r_vector_data_a  <= i_data_a_in;
                        r_vector_data_b  <= i_data_b_in;
                        r_operand_enable <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (i_vector_data_out_enable) begin
                        r_data_out     <= i_vector_data_out;
                        r_out_k_enable <= 1'b1;
                        r_out_j_enable <= (r_k == '0);
                        r_out_i_enable <= (r_k == '0) && (r_j == '0);
                        r_k            <= w_last_k ? '0 : r_k + ONE;
                    end
                end
                ST_VWAIT: begin
                    if (i_vector_ready) begin
                        if (w_last_j) begin
                            r_j <= '0;
                            r_i <= r_i + ONE;
                        end else begin
                            r_j <= r_j + ONE;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_timeout) begin
                r_i <= '0;
                r_j <= '0;
                r_k <= '0;
            end
        end
    end

`ifdef ACCELERATOR_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    // Watchdog restarts on every state change, so it measures time spent in one state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_timeout;
            if (w_next_state != r_state) begin
                r_wdog <= '0;
            end else if ((r_state == ST_RESULT) || (r_state == ST_VWAIT)) begin
                r_wdog <= r_wdog + 32'd1;
            end
        end
    end

    assign o_error = r_error;
`endif

    assign o_ready                = r_ready;
    assign o_data_in_ready        = (r_state == ST_FEED);
    assign o_data_out             = r_data_out;
    assign o_data_out_i_enable    = r_out_i_enable;
    assign o_data_out_j_enable    = r_out_j_enable;
    assign o_data_out_k_enable    = r_out_k_enable;
    assign o_vector_start         = r_vector_start;
    assign o_vector_operation     = r_operation;
    assign o_vector_size          = r_size_k;
    assign o_vector_data_a_enable = r_operand_enable;
    assign o_vector_data_b_enable = r_operand_enable;
    assign o_vector_data_a        = r_vector_data_a;
    assign o_vector_data_b        = r_vector_data_b;

endmodule
